// File: rtl/fir_filter_param.sv
// fir_filter_param
//   Parametrised serial-MAC FIR filter. Each accepted sample is shifted into
//   a delay line, then NTAPS multiply-accumulate cycles form
//   sum(coef[k] * x[k]). The accumulator is arithmetically shifted right by
//   OUT_SHIFT and trimmed to OUT_W bits. Coefficients can be rewritten at
//   runtime, but only while the filter is idle.
//
//   Optional build macro: FIR_SATURATE_EN
//     undefined : trim keeps the low OUT_W bits (two's-complement wrap)
//     defined   : trim saturates to the OUT_W signed range and adds sat_out
//
// Ports
//   clk_in          system clock, all logic on rising edge
//   rst_n_in        asynchronous active-low reset
//   audio_in        signed input sample (DATA_W)
//   valid_in        sample valid, taken only while ready_out is high
//   ready_out       high while idle and able to accept a sample
//   coef_we_in      coefficient write strobe (honoured only while idle)
//   coef_addr_in    tap index for the coefficient write
//   coef_data_in    signed coefficient value (COEF_W)
//   filtered_audio  signed filtered sample, held until the next result
//   data_ready      one-cycle pulse when filtered_audio updates
//   sat_out         (FIR_SATURATE_EN only) result was clipped, with data_ready
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for a sample; coefficient writes allowed
// S_MAC  | one multiply-accumulate per cycle, tap 0 through NTAPS-1
// S_DONE | scale and trim the accumulator, then return to S_IDLE

module fir_filter_param #(
  parameter int NTAPS     = 32,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 9,
  parameter int OUT_SHIFT = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic signed [DATA_W-1:0] audio_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic                     coef_we_in,
  input  logic [$clog2(NTAPS)-1:0] coef_addr_in,
  input  logic signed [COEF_W-1:0] coef_data_in,
  output logic signed [OUT_W-1:0]  filtered_audio,
  output logic                     data_ready
`ifdef FIR_SATURATE_EN
  ,
  output logic                     sat_out
`endif
);

  localparam int ADDR_W = $clog2(NTAPS);
  // Wide enough to hold NTAPS full-scale products without ever wrapping.
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);

  // Reset coefficient set is an identity filter: unity gain on tap 0 once
  // the output shift is applied.
  localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(1) << OUT_SHIFT;
  localparam logic [ADDR_W-1:0]        LAST_TAP   = ADDR_W'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x_line   [NTAPS];
  logic signed [COEF_W-1:0] coef_mem [NTAPS];

  logic [ADDR_W-1:0]       idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] trimmed;
  logic                    clipped;

  logic accept;
  logic coef_wr;
  logic mac_en;
  logic load_out;
  logic last_tap;
  logic addr_ok;

  assign last_tap = (idx == LAST_TAP);
  // Only relevant when NTAPS is not a power of two.
  assign addr_ok  = (32'(coef_addr_in) < NTAPS);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (valid_in) state_nxt = S_MAC;
      S_MAC:   if (last_tap) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath enables
  // ---------------------------------------------------------------------
  always_comb begin
    ready_out = 1'b0;
    accept    = 1'b0;
    coef_wr   = 1'b0;
    mac_en    = 1'b0;
    load_out  = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_out = 1'b1;
        accept    = valid_in;
        coef_wr   = coef_we_in && addr_ok;
      end
      S_MAC:   mac_en   = 1'b1;
      S_DONE:  load_out = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Coefficient memory. A write in the same idle cycle as an accepted
  // sample lands before the first MAC cycle, so that computation uses it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef_mem[k] <= (k == 0) ? COEF_UNITY : '0;
      end
    end else if (coef_wr) begin
      coef_mem[coef_addr_in] <= coef_data_in;
    end
  end

  // ---------------------------------------------------------------------
  // Delay line: newest sample at x_line[0], oldest falls off the end.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_line[k] <= '0;
      end
    end else if (accept) begin
      x_line[0] <= audio_in;
      for (int k = 1; k < NTAPS; k++) begin
        x_line[k] <= x_line[k-1];
      end
    end
  end

  // Both operands are sign-extended to the accumulator width first, so the
  // truncated ACC_W-bit product equals the true product.
  assign prod = ACC_W'(coef_mem[idx]) * ACC_W'(x_line[idx]);

  // ---------------------------------------------------------------------
  // MAC: tap index and accumulator
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      idx <= '0;
      acc <= '0;
    end else if (mac_en) begin
      acc <= acc + prod;
      // Park on tap 0 after the last term so idx never leaves the array.
      idx <= last_tap ? '0 : idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Output scaling and trim
  // ---------------------------------------------------------------------
  assign shifted = acc >>> OUT_SHIFT;

`ifdef FIR_SATURATE_EN
  localparam longint OUT_MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint OUT_MIN_L = -OUT_MAX_L - 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(OUT_MAX_L);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(OUT_MIN_L);

  always_comb begin
    trimmed = shifted[OUT_W-1:0];
    clipped = 1'b0;
    if (shifted > OUT_MAX) begin
      trimmed = OUT_MAX[OUT_W-1:0];
      clipped = 1'b1;
    end else if (shifted < OUT_MIN) begin
      trimmed = OUT_MIN[OUT_W-1:0];
      clipped = 1'b1;
    end
  end
`else
  // Plain two's-complement wrap: the upper shifted bits are simply dropped.
  logic unused_shift_bits;
  assign unused_shift_bits = ^shifted[ACC_W-1:OUT_W];
  assign trimmed           = shifted[OUT_W-1:0];
  assign clipped           = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Output register: loads on the S_DONE exit edge, so data_ready and the
  // new value appear together in the following (idle) cycle.
  // ---------------------------------------------------------------------
  logic sat_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      filtered_audio <= '0;
      data_ready     <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      data_ready <= load_out;
      sat_q      <= load_out & clipped;
      if (load_out) begin
        filtered_audio <= trimmed;
      end
    end
  end

`ifdef FIR_SATURATE_EN
  assign sat_out = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule
